// File: rtl/freq_error_counter.sv
// ============================================================================
// Module   : freq_error_counter
// Purpose  : Measures the frequency error of CLK against a 1 Hz PPS reference.
//            A gate spanning MULT+1 PPS seconds counts CLK edges; the result
//            (count minus TF*(MULT+1)) is presented as an offset-binary,
//            saturating DIFF with a RDY/ACK handshake. Consecutive gates abut
//            with no dead time.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   CLK      in   sole clock, rising edge
//   RST_N    in   asynchronous active-low reset
//   PPS      in   asynchronous 1 Hz reference pulse
//   RUN      in   enable measurement
//   CLR      in   synchronous clear of the measurement in progress
//   MULT     in   gate length is MULT+1 seconds (latched when a gate opens)
//   DIFF     out  offset-binary frequency error
//   RDY      out  DIFF valid, held until ACK
//   ACK      in   consumer accepts DIFF
//   OVF      out  current DIFF saturated
//   OVR      out  sticky: a result replaced an unacknowledged one
//   PPS_LOST out  reference missing
// ----------------------------------------------------------------------------
// Build option
//   FEC_PPS_WINDOW_EN : when defined, a PPS edge arriving earlier than
//                       TF-WIN cycles into a second is treated as a glitch.
// ============================================================================
`default_nettype none

module freq_error_counter #(
  parameter int TF     = 10_000_000,
  parameter int MULT_W = 8,
  parameter int CNT_W  = 40,
  parameter int DIFF_W = 16,
  parameter int WIN    = 1000
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              PPS,
  input  logic              RUN,
  input  logic              CLR,
  input  logic [MULT_W-1:0] MULT,
  output logic [DIFF_W-1:0] DIFF,
  output logic              RDY,
  input  logic              ACK,
  output logic              OVF,
  output logic              OVR,
  output logic              PPS_LOST
);

  // Per-second timer must reach past the loss limit TF + TF/8.
  localparam int TMR_W = $clog2(TF + TF / 8 + 2);

  localparam logic [TMR_W-1:0] LOST_LIM = TMR_W'(TF + TF / 8);
  localparam logic [CNT_W:0]   TF_EXT   = (CNT_W + 1)'(TF);

  // Signed saturation limits of a DIFF_W-bit two's-complement error.
  localparam logic signed [CNT_W:0] ERR_MAX =
    $signed({{(CNT_W + 2 - DIFF_W){1'b0}}, {(DIFF_W - 1){1'b1}}});
  localparam logic signed [CNT_W:0] ERR_MIN =
    $signed({{(CNT_W + 2 - DIFF_W){1'b1}}, {(DIFF_W - 1){1'b0}}});

  if (WIN >= TF) begin : g_win_check
    $error("freq_error_counter: WIN must be smaller than TF");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    COUNT = 2'd2
  } state_t;

  state_t state, state_nx;

  // PPS synchronizer (s1, s2) and edge-detect flop (s3).
  logic pps_s1, pps_s2, pps_s3;
  logic pps_edge;

  logic [CNT_W-1:0]  cyc_cnt;
  logic [MULT_W-1:0] sec_cnt;
  logic [TMR_W-1:0]  sec_tmr;
  logic [MULT_W-1:0] mult_l;

  // Result pipeline: the error is captured on the closing edge and turned
  // into DIFF on the following edge.
  logic                    res_pend;
  logic signed [CNT_W:0]   err_r;

  logic                    pps_acc;
  logic                    sec_last;
  logic                    tmr_over;
  logic                    start_gate;
  logic                    close_gate;
  logic                    sec_inc;
  logic                    count_en;
  logic                    lost;

  logic [CNT_W-1:0]        count_now;
  logic [CNT_W:0]          nominal;
  logic signed [CNT_W:0]   err_now;
  logic [DIFF_W-1:0]       diff_sat;
  logic                    sat_flag;

  assign pps_edge = pps_s2 & ~pps_s3;

`ifdef FEC_PPS_WINDOW_EN
  // Edges arriving too early in a second are glitches; counting continues.
  assign pps_acc = pps_edge & (sec_tmr >= TMR_W'(TF - WIN));
`else
  assign pps_acc = pps_edge;
`endif

  // This edge completes second number sec_cnt+1; the gate ends at mult_l+1.
  assign sec_last = (sec_cnt == mult_l);
  assign tmr_over = (sec_tmr > LOST_LIM);

  // The closing edge itself is counted, so the gate count is cyc_cnt + 1.
  assign count_now = cyc_cnt + CNT_W'(1);
  assign nominal   = TF_EXT * ((CNT_W + 1)'(mult_l) + (CNT_W + 1)'(1));
  assign err_now   = $signed({1'b0, count_now}) - $signed(nominal);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    start_gate = 1'b0;
    close_gate = 1'b0;
    sec_inc    = 1'b0;
    count_en   = 1'b0;
    lost       = 1'b0;
    if (!RUN) begin
      state_nx = IDLE;
    end else if (CLR) begin
      state_nx = ARM;
    end else begin
      case (state)
        IDLE: state_nx = ARM;
        ARM: begin
          if (pps_edge) begin
            state_nx   = COUNT;
            start_gate = 1'b1;
          end
        end
        COUNT: begin
          if (pps_acc) begin
            if (sec_last) begin
              // Closing edge of one gate is the opening edge of the next.
              close_gate = 1'b1;
              start_gate = 1'b1;
            end else begin
              sec_inc = 1'b1;
            end
          end else if (tmr_over) begin
            lost     = 1'b1;
            state_nx = ARM;
          end else begin
            count_en = 1'b1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // ------------------------------------------------------ Saturation
  always_comb begin
    diff_sat = {err_r[DIFF_W-1] ^ 1'b1, err_r[DIFF_W-2:0]};
    sat_flag = 1'b0;
    if (err_r > ERR_MAX) begin
      diff_sat = {DIFF_W{1'b1}};
      sat_flag = 1'b1;
    end else if (err_r < ERR_MIN) begin
      diff_sat = {DIFF_W{1'b0}};
      sat_flag = 1'b1;
    end
  end

  // ------------------------------------------------------ Datapath
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pps_s1   <= 1'b0;
      pps_s2   <= 1'b0;
      pps_s3   <= 1'b0;
      cyc_cnt  <= '0;
      sec_cnt  <= '0;
      sec_tmr  <= '0;
      mult_l   <= '0;
      res_pend <= 1'b0;
      err_r    <= '0;
      DIFF     <= {1'b1, {(DIFF_W - 1){1'b0}}};
      RDY      <= 1'b0;
      OVF      <= 1'b0;
      OVR      <= 1'b0;
      PPS_LOST <= 1'b0;
    end else begin
      pps_s1 <= PPS;
      pps_s2 <= pps_s1;
      pps_s3 <= pps_s2;

      if (start_gate) begin
        mult_l  <= MULT;
        cyc_cnt <= '0;
        sec_cnt <= '0;
        sec_tmr <= '0;
      end else if (sec_inc) begin
        cyc_cnt <= cyc_cnt + CNT_W'(1);
        sec_cnt <= sec_cnt + MULT_W'(1);
        sec_tmr <= '0;
      end else if (count_en) begin
        cyc_cnt <= cyc_cnt + CNT_W'(1);
        sec_tmr <= sec_tmr + TMR_W'(1);
      end

      res_pend <= close_gate;
      if (close_gate) begin
        err_r <= err_now;
      end

      if (CLR) begin
        RDY      <= 1'b0;
        OVR      <= 1'b0;
        PPS_LOST <= 1'b0;
      end else begin
        if (res_pend) begin
          DIFF <= diff_sat;
          OVF  <= sat_flag;
          RDY  <= 1'b1;
          if (RDY && !ACK) begin
            OVR <= 1'b1;
          end
        end else if (RDY && ACK) begin
          RDY <= 1'b0;
        end

        if (lost) begin
          PPS_LOST <= 1'b1;
        end else if (start_gate || sec_inc) begin
          PPS_LOST <= 1'b0;
        end
      end
    end
  end

endmodule

`default_nettype wire
